// File: rtl/sar_adc_sample_sequencer.sv
// Paces SAR ADC conversions from a sample-period timer, re-arms the controller after each result,
// averages 2**AVG_LOG2 results per word and queues averaged words in a small valid/ready FIFO.
module sar_adc_sample_sequencer #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [15:0]     period,
  input  logic            clear_flags,
  output logic            adc_rst_n,
  output logic            adc_start,
  input  logic [BITS-1:0] adc_val,
  input  logic            adc_out_valid,
  output logic [BITS-1:0] sample_data,
  output logic            sample_valid,
  input  logic            sample_ready,
  output logic            overflow,
  output logic            timeout_err
);

  localparam int unsigned ACC_W = BITS + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TICK,
    S_START,
    S_CONV
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       tick_cnt;
  logic              pending;
  logic [TO_W-1:0]   to_cnt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  avg_cnt;
  logic [BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  logic              tick;
  logic              capture;
  logic              timed_out;
  logic [ACC_W-1:0]  acc_sum;
  logic              push;
  logic [BITS-1:0]   push_data;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              drop;
  logic [PTR_W-1:0]  rd_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic [BITS-1:0]   head_nxt;

  // Datapath decode for the current cycle
  always_comb begin
    tick      = enable && (tick_cnt == period);
    capture   = (state_q == S_CONV) && enable && adc_out_valid;
    timed_out = (state_q == S_CONV) && enable && !adc_out_valid && (to_cnt == TO_LAST);
    acc_sum   = acc + ACC_W'(adc_val);
    push      = capture && (avg_cnt == CNT_LAST);
    push_data = BITS'(acc_sum >> AVG_LOG2);
    pop       = sample_valid && sample_ready;
    full      = (level == LVL_FULL);
    push_ok   = push && (!full || pop);
    drop      = push && full && !pop;
    rd_nxt    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt = level;
    if (push_ok && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (!push_ok && pop) begin
      level_nxt = level - LVL_W'(1);
    end
    // A push landing on the next head slot bypasses the memory read
    head_nxt = (push_ok && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
  end

  // Sequencer next state; leaving enable always wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_ARM;
      S_ARM:       state_d = enable ? S_WAIT_TICK : S_IDLE;
      S_WAIT_TICK: begin
        if (!enable) state_d = S_IDLE;
        else if (pending || tick) state_d = S_START;
      end
      S_START:     state_d = enable ? S_CONV : S_IDLE;
      S_CONV: begin
        if (!enable) state_d = S_IDLE;
        else if (capture || timed_out) state_d = S_ARM;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      adc_rst_n    <= 1'b0;
      adc_start    <= 1'b0;
      tick_cnt     <= '0;
      pending      <= 1'b0;
      to_cnt       <= '0;
      acc          <= '0;
      avg_cnt      <= '0;
      mem          <= '{default: '0};
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      overflow     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Outputs follow the state being entered so they line up with it
      adc_rst_n <= (state_d == S_WAIT_TICK) || (state_d == S_START) || (state_d == S_CONV);
      adc_start <= (state_d == S_START);

      tick_cnt <= (!enable || tick) ? 16'd0 : tick_cnt + 16'd1;

      // Ticks arriving while one is already pending merge into it
      if (!enable) begin
        pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end else if (state_q == S_START) begin
        pending <= 1'b0;
      end

      if (state_q == S_START) begin
        to_cnt <= '0;
      end else if (state_q == S_CONV) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (!enable) begin
        acc     <= '0;
        avg_cnt <= '0;
      end else if (capture) begin
        if (push) begin
          acc     <= '0;
          avg_cnt <= '0;
        end else begin
          acc     <= acc_sum;
          avg_cnt <= avg_cnt + CNT_W'(1);
        end
      end

      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr       <= rd_nxt;
      level        <= level_nxt;
      sample_valid <= (level_nxt != '0);
      sample_data  <= head_nxt;

      // Set events take priority over clear_flags
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (timed_out) begin
        timeout_err <= 1'b1;
      end else if (clear_flags) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_sample_sequencer.sv
// Directed bench for sar_adc_sample_sequencer with a behavioural SAR controller model.
module tb_sar_adc_sample_sequencer;

  localparam int unsigned BITS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd0;
  logic        clear_flags = 1'b0;
  logic        adc_rst_n;
  logic        adc_start;
  logic [7:0]  adc_val = 8'h00;
  logic        adc_out_valid = 1'b0;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overflow;
  logic        timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nres = 0;

  logic       m_busy = 1'b0;
  logic [3:0] m_cnt = 4'd0;
  logic       m_stuck = 1'b0;
  logic [7:0] vals[$];
  logic [7:0] got[$];
  int         start_cyc[$];

  always #5 clk = ~clk;

  sar_adc_sample_sequencer #(
    .BITS(8), .AVG_LOG2(2), .FIFO_DEPTH(4), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .clear_flags(clear_flags),
    .adc_rst_n(adc_rst_n), .adc_start(adc_start), .adc_val(adc_val),
    .adc_out_valid(adc_out_valid), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overflow(overflow), .timeout_err(timeout_err)
  );

  // Controller model: start in cycle t -> out_valid first visible in cycle t+BITS+2
  always @(posedge clk) begin
    if (!adc_rst_n) begin
      m_busy        <= 1'b0;
      m_cnt         <= 4'd0;
      adc_out_valid <= 1'b0;
    end else if (adc_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 4'd0;
    end else if (m_busy) begin
      if (m_cnt == 4'(BITS)) begin
        m_busy <= 1'b0;
        if (!m_stuck) begin
          adc_out_valid <= 1'b1;
          if (vals.size() > 0) adc_val <= vals.pop_front();
          else adc_val <= 8'h00;
          nres <= nres + 1;
        end
      end else begin
        m_cnt <= m_cnt + 4'd1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid && sample_ready) got.push_back(sample_data);
    if (adc_start) start_cyc.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    @(negedge clk);
    total++; if (adc_rst_n !== 1'b0) begin bad++; $display("FAIL rst_adc_rst_n got=%b exp=0", adc_rst_n); end
    total++; if (adc_start !== 1'b0) begin bad++; $display("FAIL rst_adc_start got=%b exp=0", adc_start); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rst_sample_valid got=%b exp=0", sample_valid); end
    total++; if (sample_data !== 8'h00) begin bad++; $display("FAIL rst_sample_data got=%h exp=00", sample_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
    step(1);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_period;
    int n;
    got.delete(); start_cyc.delete(); vals.delete();
    repeat (4) vals.push_back(8'h40);
    period = 16'd19; sample_ready = 1'b1; enable = 1'b1;
    n = 0;
    while (got.size() < 1 && n < 200) begin step(1); n++; end
    enable = 1'b0;
    total++;
    if (got.size() != 1) begin bad++; $display("FAIL period_word_count got=%0d exp=1", got.size()); end
    else if (got[0] !== 8'h40) begin bad++; $display("FAIL period_word got=%h exp=40", got[0]); end
    total++;
    if (start_cyc.size() < 4) begin bad++; $display("FAIL period_starts got=%0d exp=4", start_cyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        if (start_cyc[i+1] - start_cyc[i] != 20) begin
          bad++;
          $display("FAIL period_interval%0d got=%0d exp=20", i, start_cyc[i+1] - start_cyc[i]);
          break;
        end
      end
    end
    step(3);
  endtask

  task automatic test_truncate;
    int n;
    got.delete(); vals.delete();
    vals.push_back(8'h01); vals.push_back(8'h02); vals.push_back(8'h03); vals.push_back(8'h04);
    period = 16'd15; sample_ready = 1'b1; enable = 1'b1;
    n = 0;
    while (got.size() < 1 && n < 200) begin step(1); n++; end
    enable = 1'b0;
    step(2);
    @(negedge clk);
    total++;
    if (got.size() != 1) begin bad++; $display("FAIL trunc_word_count got=%0d exp=1", got.size()); end
    else if (got[0] !== 8'h02) begin bad++; $display("FAIL trunc_word got=%h exp=02", got[0]); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL trunc_empty got=%b exp=0", sample_valid); end
  endtask

  task automatic test_overflow;
    int n;
    logic [7:0] exp_w [4];
    exp_w[0] = 8'h10; exp_w[1] = 8'h20; exp_w[2] = 8'h30; exp_w[3] = 8'h40;
    got.delete(); vals.delete();
    for (int w = 1; w <= 5; w++) repeat (4) vals.push_back(8'(w * 16));
    step(1);
    sample_ready = 1'b0; period = 16'd15; enable = 1'b1;
    n = 0;
    while (overflow !== 1'b1 && n < 600) begin step(1); n++; end
    enable = 1'b0;
    step(2);
    @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", sample_valid); end
    total++; if (sample_data !== 8'h10) begin bad++; $display("FAIL ovf_head got=%h exp=10", sample_data); end
    step(1);
    sample_ready = 1'b1;
    step(8);
    sample_ready = 1'b0;
    @(negedge clk);
    total++;
    if (got.size() != 4) begin bad++; $display("FAIL ovf_drain_count got=%0d exp=4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        if (got[i] !== exp_w[i]) begin
          bad++; $display("FAIL ovf_order%0d got=%h exp=%h", i, got[i], exp_w[i]); break;
        end
      end
    end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", sample_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    step(1);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_timeout;
    int n;
    int t0;
    int t1;
    start_cyc.delete(); vals.delete();
    step(1);
    m_stuck = 1'b1; period = 16'd15; sample_ready = 1'b0; enable = 1'b1;
    n = 0;
    while (start_cyc.size() < 1 && n < 100) begin step(1); n++; end
    t0 = (start_cyc.size() > 0) ? start_cyc[0] : 0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 80) begin step(1); n++; end
    t1 = cyc;
    total++; if (t1 - t0 != 33) begin bad++; $display("FAIL to_latency got=%0d exp=33", t1 - t0); end
    total++; if (adc_rst_n !== 1'b0) begin bad++; $display("FAIL to_rearm_low got=%b exp=0", adc_rst_n); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL to_no_push got=%b exp=0", sample_valid); end
    step(1);
    total++; if (adc_rst_n !== 1'b1) begin bad++; $display("FAIL to_wait_high got=%b exp=1", adc_rst_n); end
    n = 0;
    while (start_cyc.size() < 2 && n < 60) begin step(1); n++; end
    total++; if (start_cyc.size() < 2) begin bad++; $display("FAIL to_restart got=%0d exp=2", start_cyc.size()); end
    enable = 1'b0;
    m_stuck = 1'b0;
    step(2);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
  endtask

  task automatic test_full_pop_push;
    int n;
    int base;
    logic done;
    logic [7:0] exp_w [5];
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44; exp_w[4] = 8'h55;
    got.delete(); vals.delete();
    for (int w = 1; w <= 5; w++) repeat (4) vals.push_back(8'(w * 17));
    step(1);
    sample_ready = 1'b0; period = 16'd15; base = nres; done = 1'b0; enable = 1'b1;
    n = 0;
    while (!done && n < 600) begin
      step(1); n++;
      // Raise ready only in the cycle the fifth word is captured
      if (adc_out_valid && nres == base + 20) begin
        sample_ready = 1'b1;
        step(1);
        sample_ready = 1'b0;
        done = 1'b1;
      end
    end
    enable = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL pp_reached got=%b exp=1", done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
    total++;
    if (got.size() != 1) begin bad++; $display("FAIL pp_pop_count got=%0d exp=1", got.size()); end
    else if (got[0] !== 8'h11) begin bad++; $display("FAIL pp_pop_word got=%h exp=11", got[0]); end
    step(1);
    sample_ready = 1'b1;
    step(8);
    sample_ready = 1'b0;
    @(negedge clk);
    total++;
    if (got.size() != 5) begin bad++; $display("FAIL pp_drain_count got=%0d exp=5", got.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        if (got[i] !== exp_w[i]) begin
          bad++; $display("FAIL pp_order%0d got=%h exp=%h", i, got[i], exp_w[i]); break;
        end
      end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow_end got=%b exp=0", overflow); end
  endtask

  task automatic test_disable;
    int n;
    int base;
    got.delete(); vals.delete();
    vals.push_back(8'hFF); vals.push_back(8'hFF);
    vals.push_back(8'h08); vals.push_back(8'h08); vals.push_back(8'h0C); vals.push_back(8'h0C);
    step(1);
    sample_ready = 1'b1; period = 16'd15; base = nres; enable = 1'b1;
    n = 0;
    while (nres < base + 2 && n < 100) begin step(1); n++; end
    step(1);
    enable = 1'b0;
    step(2);
    @(negedge clk);
    total++; if (adc_rst_n !== 1'b0) begin bad++; $display("FAIL dis_adc_rst_n got=%b exp=0", adc_rst_n); end
    total++; if (adc_start !== 1'b0) begin bad++; $display("FAIL dis_adc_start got=%b exp=0", adc_start); end
    total++; if (got.size() != 0) begin bad++; $display("FAIL dis_no_word got=%0d exp=0", got.size()); end
    step(5);
    enable = 1'b1;
    n = 0;
    while (got.size() < 1 && n < 200) begin step(1); n++; end
    enable = 1'b0;
    total++;
    if (got.size() != 1) begin bad++; $display("FAIL dis_word_count got=%0d exp=1", got.size()); end
    else if (got[0] !== 8'h0A) begin bad++; $display("FAIL dis_fresh_avg got=%h exp=0a", got[0]); end
    step(3);
  endtask

  initial begin
    test_reset();
    test_period();
    test_truncate();
    test_overflow();
    test_timeout();
    test_full_pop_push();
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
